mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, MSB index of the RAM word address; the RAM holds 2^(ADDR_WIDTH+1) words.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  reset; synchronous and active-low.
REQ-004 if_req_valid  in  1  instruction-fetch request present.
REQ-005 if_req_ready  out  1  fetch request accepted this cycle.
REQ-006 if_req_addr  in  32  fetch byte address.
REQ-007 if_rsp_valid / if_rsp_data  out  1 / 32  fetch response strobe and instruction word.
REQ-008 d_req_valid / d_req_ready  in / out  1 / 1  load/store request handshake.
REQ-009 d_req_we, d_req_size, d_req_unsigned  in  1, 2, 1  store select; size 0=byte, 1=half, 2/3=word; zero-extend loads.
REQ-010 d_req_addr / d_req_wdata  in  32 / 32  byte address and store data, LSB-aligned.
REQ-011 d_rsp_valid / d_rsp_rdata / d_rsp_err  out  1 / 32 / 1  data response, extended load data, misalignment error.
REQ-012 ram_read_enable, ram_read_addr [ADDR_WIDTH:0], ram_read_data 32 in: RAM read port.
REQ-013 ram_write_enable 4, ram_write_addr [ADDR_WIDTH:0], ram_write_data 32: RAM byte-lane write port; ram_clk_en tied 1.

Function
REQ-014 The FSM SHALL have states IDLE, IF_RSP, D_RSP; requests are granted only in IDLE.
REQ-015 In IDLE, if_req_ready/d_req_ready SHALL assert combinationally for the granted port only; in IF_RSP and D_RSP both SHALL be 0.
REQ-016 Single requester in IDLE SHALL be granted; both valid SHALL grant the port not granted last (round-robin flop last_grant).
REQ-017 Grant cycle T SHALL drive the RAM: word address = addr[ADDR_WIDTH+2:2]; read -> ram_read_enable=1; store -> byte strobes; otherwise all RAM enables 0.
REQ-018 Store strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; ram_write_data replicates the byte (x4) or half (x2).
REQ-019 Cycle T+1 SHALL be IF_RSP or D_RSP with the matching rsp_valid=1 for exactly one cycle; next state IDLE; throughput one access per 2 cycles.
REQ-020 if_rsp_data SHALL equal ram_read_data in IF_RSP; otherwise 0.
REQ-021 Load d_rsp_rdata SHALL select the lane by registered addr[1:0] and sign-extend unless d_req_unsigned; store response rdata SHALL be 0.
REQ-022 Responses have no backpressure; requesters SHALL accept rsp_valid unconditionally.
REQ-023 Requester signals SHALL be sampled only in the grant cycle; later changes do not affect the in-flight access.

Reset
REQ-024 While rst=0: state IDLE, last_grant=DATA (fetch wins first contention), all rsp_valid/err 0, both readies 0, RAM enables 0.
REQ-025 Reset in IF_RSP/D_RSP SHALL abort the response; a write granted in the cycle before reset has already committed.

Configuration
REQ-026 Macro MISALIGN_TRAP_EN: defined -> half with addr[0]=1 or word with addr[1:0]!=0 SHALL drive no RAM enables and respond in D_RSP with d_rsp_err=1, rdata 0.
REQ-027 MISALIGN_TRAP_EN undefined -> d_rsp_err tied 0; words align down, halves use addr[1] only.

Structure
REQ-028 Size encodings, FSM state enum and grant enum SHALL live in the shared types.svh package.
REQ-029 Lane strobe/replication and load extraction/extension SHALL be one combinational sub-module, lsu_align.

Verification
REQ-030 Reset, then fetch 0x0000_0010 with mem[4]=0x0013_0093 -> if_req_ready at T, if_rsp_valid at T+1, data 0x0013_0093.
REQ-031 Both valid from IDLE after reset -> fetch granted first, data next IDLE, then alternation while both stay valid.
REQ-032 Store byte 0xAB to 0x0000_0103 -> ram_write_enable=4'b1000, ram_write_addr=0x40, ram_write_data=0xABABABAB, d_rsp_valid at T+1.
REQ-033 Load half signed/unsigned at 0x0000_0102, word 0x8001_7F00 -> rdata 0xFFFF_8001 / 0x0000_8001.
REQ-034 Word load at 0x0000_0006: with MISALIGN_TRAP_EN -> d_rsp_err=1, ram_read_enable=0; without -> reads word 0x1, err=0.
REQ-035 rst=0 during D_RSP -> d_rsp_valid=0 next cycle, state IDLE, next request served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data RAM arbiter: access sizes, FSM states, grant owner
// and the captured data-request context.
package mem_arbiter_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      SIZE_BYTE     = 2'd0,
      SIZE_HALF     = 2'd1,
      SIZE_WORD     = 2'd2,
      SIZE_WORD_ALT = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_RSP = 2'd1,
      D_RSP  = 2'd2
   } state_e;

   typedef enum logic {
      GRANT_FETCH = 1'b0,
      GRANT_DATA  = 1'b1
   } grant_e;

   // Data-side request fields that must survive into the response cycle
   typedef struct packed {
      logic       we;
      size_e      size;
      logic       is_unsigned;
      logic [1:0] addr_lo;
      logic       err;
   } d_ctx_t;

   function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         SIZE_BYTE: mis = 1'b0;
         SIZE_HALF: mis = addr_lo[0];
         default:   mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_arbiter_lsu_align.sv
// Byte-lane alignment: store strobes/replication on the request side, lane
// extraction and sign/zero extension on the load-response side.
module lsu_align
   import mem_arbiter_pkg::*;
(
   input  size_e              st_size,
   input  logic [1:0]         st_addr_lo,
   input  logic [DATA_W-1:0]  st_wdata,
   output logic [STRB_W-1:0]  st_strobe,
   output logic [DATA_W-1:0]  st_data,
   input  size_e              ld_size,
   input  logic [1:0]         ld_addr_lo,
   input  logic               ld_unsigned,
   input  logic [DATA_W-1:0]  ld_rdata,
   output logic [DATA_W-1:0]  ld_data
);

   logic [DATA_W-1:0] byte_sh;
   logic [DATA_W-1:0] half_sh;

   always_comb begin : store_lanes
      st_strobe = 4'b1111;
      st_data   = st_wdata;
      case (st_size)
         SIZE_BYTE: begin
            st_strobe = 4'b0001 << st_addr_lo;
            st_data   = {4{st_wdata[7:0]}};
         end
         SIZE_HALF: begin
            st_strobe = 4'b0011 << {st_addr_lo[1], 1'b0};
            st_data   = {2{st_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Shift the addressed lane down to bit 0; words are taken as-is (aligned down)
   always_comb begin : load_lanes
      byte_sh = ld_rdata >> {ld_addr_lo, 3'b000};
      half_sh = ld_rdata >> {ld_addr_lo[1], 4'b0000};
      case (ld_size)
         SIZE_BYTE: ld_data = ld_unsigned ? {24'd0, byte_sh[7:0]}
                                          : {{24{byte_sh[7]}}, byte_sh[7:0]};
         SIZE_HALF: ld_data = ld_unsigned ? {16'd0, half_sh[15:0]}
                                          : {{16{half_sh[15]}}, half_sh[15:0]};
         default:   ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port-per-direction RAM between instruction
// fetch and load/store; one access per two cycles. Optional macro: MISALIGN_TRAP_EN.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_valid,
   output logic                  if_req_ready,
   input  logic [31:0]           if_req_addr,
   output logic                  if_rsp_valid,
   output logic [31:0]           if_rsp_data,
   input  logic                  d_req_valid,
   output logic                  d_req_ready,
   input  logic                  d_req_we,
   input  logic [1:0]            d_req_size,
   input  logic                  d_req_unsigned,
   input  logic [31:0]           d_req_addr,
   input  logic [31:0]           d_req_wdata,
   output logic                  d_rsp_valid,
   output logic [31:0]           d_rsp_rdata,
   output logic                  d_rsp_err,
   output logic                  ram_clk_en,
   output logic                  ram_read_enable,
   output logic [ADDR_WIDTH:0]   ram_read_addr,
   input  logic [31:0]           ram_read_data,
   output logic [3:0]            ram_write_enable,
   output logic [ADDR_WIDTH:0]   ram_write_addr,
   output logic [31:0]           ram_write_data
);

   state_e  state_q, state_d;
   grant_e  last_grant_q, last_grant_d;
   d_ctx_t  ctx_q, ctx_d;

   logic                grant_if;
   logic                grant_d;
   logic                trap_c;
   logic [ADDR_WIDTH:0] if_word;
   logic [ADDR_WIDTH:0] d_word;
   logic [3:0]          st_strobe;
   logic [31:0]         st_data;
   logic [31:0]         ld_data;
   logic                unused_bits;

   assign ram_clk_en = 1'b1;
   assign if_word    = if_req_addr[ADDR_WIDTH+2:2];
   assign d_word     = d_req_addr[ADDR_WIDTH+2:2];

   assign unused_bits = &{1'b0, if_req_addr[1:0],
                          if_req_addr[31:ADDR_WIDTH+3], d_req_addr[31:ADDR_WIDTH+3]};

`ifdef MISALIGN_TRAP_EN
   assign trap_c = misaligned(size_e'(d_req_size), d_req_addr[1:0]);
`else
   assign trap_c = 1'b0;
`endif

   lsu_align u_align (
      .st_size     (size_e'(d_req_size)),
      .st_addr_lo  (d_req_addr[1:0]),
      .st_wdata    (d_req_wdata),
      .st_strobe   (st_strobe),
      .st_data     (st_data),
      .ld_size     (ctx_q.size),
      .ld_addr_lo  (ctx_q.addr_lo),
      .ld_unsigned (ctx_q.is_unsigned),
      .ld_rdata    (ram_read_data),
      .ld_data     (ld_data)
   );

   always_ff @(posedge clk) begin : state_reg
      if (!rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_DATA;
         ctx_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         ctx_q        <= ctx_d;
      end
   end

   // Grant, RAM drive and next-state; nothing is granted while reset is held
   always_comb begin : next_state
      state_d          = state_q;
      last_grant_d     = last_grant_q;
      ctx_d            = ctx_q;
      grant_if         = 1'b0;
      grant_d          = 1'b0;
      if_req_ready     = 1'b0;
      d_req_ready      = 1'b0;
      ram_read_enable  = 1'b0;
      ram_read_addr    = '0;
      ram_write_enable = 4'b0000;
      ram_write_addr   = '0;
      ram_write_data   = '0;

      case (state_q)
         IDLE: begin
            if (rst) begin
               if (if_req_valid && (!d_req_valid || last_grant_q == GRANT_DATA)) begin
                  grant_if = 1'b1;
               end else if (d_req_valid) begin
                  grant_d = 1'b1;
               end
            end
         end
         IF_RSP:  state_d = IDLE;
         D_RSP:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (grant_if) begin
         if_req_ready    = 1'b1;
         ram_read_enable = 1'b1;
         ram_read_addr   = if_word;
         state_d         = IF_RSP;
         last_grant_d    = GRANT_FETCH;
      end

      if (grant_d) begin
         d_req_ready       = 1'b1;
         ctx_d.we          = d_req_we;
         ctx_d.size        = size_e'(d_req_size);
         ctx_d.is_unsigned = d_req_unsigned;
         ctx_d.addr_lo     = d_req_addr[1:0];
         ctx_d.err         = trap_c;
         state_d           = D_RSP;
         last_grant_d      = GRANT_DATA;
         if (!trap_c) begin
            ram_read_addr  = d_word;
            ram_write_addr = d_word;
            if (d_req_we) begin
               ram_write_enable = st_strobe;
               ram_write_data   = st_data;
            end else begin
               ram_read_enable = 1'b1;
            end
         end
      end
   end

   // Response strobes follow the state but drop as soon as reset is applied
   assign if_rsp_valid = rst && (state_q == IF_RSP);
   assign d_rsp_valid  = rst && (state_q == D_RSP);
   assign if_rsp_data  = if_rsp_valid ? ram_read_data : 32'd0;
   assign d_rsp_rdata  = (d_rsp_valid && !ctx_q.we && !ctx_q.err) ? ld_data : 32'd0;

`ifdef MISALIGN_TRAP_EN
   assign d_rsp_err = d_rsp_valid && ctx_q.err;
`else
   assign d_rsp_err = 1'b0;
`endif

endmodule
